// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: select encoding,
// skid-buffer occupancy states and the legal output-width check.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_R   = 3'd0,
        IMM_I   = 3'd1,
        IMM_S   = 3'd2,
        IMM_B   = 3'd3,
        IMM_U   = 3'd4,
        IMM_J   = 3'd5,
        IMM_Z   = 3'd6,
        IMM_RSV = 3'd7
    } imm_sel_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: assembles the 32-bit immediate for the
// selected format, then sign-extends it from bit 31 to XLEN.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    // Z keeps bit 31 clear, so one uniform sign extension covers every format.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_sel_e'(sel))
            IMM_R:   imm32 = '0;
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, instr[19:15]};
            IMM_RSV: illegal = 1'b1;
            default: imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered valid/ready immediate generator with a 2-entry skid buffer so
// in_ready comes straight from a flop. Buffer holds extracted {imm, illegal}.
//
// state     | meaning
// BUF_EMPTY | no word held, out_valid low
// BUF_ONE   | main entry drives outputs, skid free
// BUF_TWO   | main and skid both full, in_ready low
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt
);

    generate
        if (!xlen_ok(XLEN)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    buf_state_e      state;
    logic [XLEN-1:0] main_imm;
    logic            main_ill;
    logic [XLEN-1:0] skid_imm;
    logic            skid_ill;
    logic [XLEN-1:0] ext_imm;
    logic            ext_ill;
    logic            in_xfer;
    logic            out_xfer;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (instr),
        .sel     (sel),
        .imm     (ext_imm),
        .illegal (ext_ill)
    );

    assign in_xfer   = in_valid && in_ready;
    assign out_valid = (state != BUF_EMPTY);
    assign out_xfer  = out_valid && out_ready;
    assign imm_out   = main_imm;
    assign illegal   = main_ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUF_EMPTY;
            in_ready <= 1'b1;
            main_imm <= '0;
            main_ill <= 1'b0;
            skid_imm <= '0;
            skid_ill <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_xfer) begin
                        main_imm <= ext_imm;
                        main_ill <= ext_ill;
                        state    <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_imm <= ext_imm;
                        main_ill <= ext_ill;
                    end else if (in_xfer) begin
                        skid_imm <= ext_imm;
                        skid_ill <= ext_ill;
                        state    <= BUF_TWO;
                        in_ready <= 1'b0;
                    end else if (out_xfer) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (out_xfer) begin
                        main_imm <= skid_imm;
                        main_ill <= skid_ill;
                        state    <= BUF_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= BUF_EMPTY;
                    in_ready <= 1'b1;
                end
            endcase

            if (in_xfer && ext_ill && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/CNT_W=8 and a 64-bit/CNT_W=2 instance share
// stimulus and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  sel = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    logic [7:0]  err_a;
    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    logic [1:0]  err_b;

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .sel(sel), .out_valid(out_valid_a), .out_ready(out_ready),
        .imm_out(imm_a), .illegal(illegal_a), .err_cnt(err_a)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .sel(sel), .out_valid(out_valid_b), .out_ready(out_ready),
        .imm_out(imm_b), .illegal(illegal_b), .err_cnt(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint imm;
        bit     ill;
    } word_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    word_t model_q[$];
    int    exp_err_a = 0;
    int    exp_err_b = 0;
    int    n_checks  = 0;
    int    n_fail    = 0;
    vec_t  tbl[10];

    localparam longint P31 = 64'sd2147483648;
    localparam longint P32 = 64'sd4294967296;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint fld(input logic [31:0] ins, input int lo, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return longint'((ins >> lo) & mask);
    endfunction

    // Immediate as a signed integer, built from field values with plain arithmetic.
    function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] s);
        longint v;
        v = 0;
        case (s)
            3'd1: begin v = fld(ins, 20, 12); if (v >= 2048) v -= 4096; end
            3'd2: begin v = fld(ins, 25, 7) * 32 + fld(ins, 7, 5); if (v >= 2048) v -= 4096; end
            3'd3: begin
                v = fld(ins, 31, 1) * 4096 + fld(ins, 7, 1) * 2048
                  + fld(ins, 25, 6) * 32 + fld(ins, 8, 4) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd4: begin v = fld(ins, 12, 20) * 4096; if (v >= P31) v -= P32; end
            3'd5: begin
                v = fld(ins, 31, 1) * 1048576 + fld(ins, 12, 8) * 4096
                  + fld(ins, 20, 1) * 2048 + fld(ins, 21, 10) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            3'd6: v = fld(ins, 15, 5);
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic check_outputs();
        logic [63:0] e;
        chk("in_ready_a", {63'd0, in_ready_a}, {63'd0, model_q.size() < 2});
        chk("in_ready_b", {63'd0, in_ready_b}, {63'd0, model_q.size() < 2});
        chk("out_valid_a", {63'd0, out_valid_a}, {63'd0, model_q.size() > 0});
        chk("out_valid_b", {63'd0, out_valid_b}, {63'd0, model_q.size() > 0});
        if (model_q.size() > 0) begin
            e = model_q[0].imm;
            chk("imm_a", {32'd0, imm_a}, {32'd0, e[31:0]});
            chk("imm_b", imm_b, e);
            chk("illegal_a", {63'd0, illegal_a}, {63'd0, model_q[0].ill});
            chk("illegal_b", {63'd0, illegal_b}, {63'd0, model_q[0].ill});
        end
        chk("err_cnt_a", {56'd0, err_a}, 64'(exp_err_a));
        chk("err_cnt_b", {62'd0, err_b}, 64'(exp_err_b));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the falling edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] s,
                         input logic ordy);
        bit    acc_in, acc_out;
        word_t w;
        in_valid  = v;
        instr     = ins;
        sel       = s;
        out_ready = ordy;
        @(posedge clk);
        acc_in  = v && (model_q.size() < 2);
        acc_out = ordy && (model_q.size() > 0);
        if (acc_out) void'(model_q.pop_front());
        if (acc_in) begin
            w.imm = ref_imm(ins, s);
            w.ill = (s == 3'd7);
            model_q.push_back(w);
            if (s == 3'd7) begin
                if (exp_err_a < 255) exp_err_a++;
                if (exp_err_b < 3) exp_err_b++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        tbl[0] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0};
        tbl[1] = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 1'b0};
        tbl[2] = '{32'hFE000CE3, 3'd3, 32'hFFFFFFF8, 1'b0};
        tbl[3] = '{32'h123450B7, 3'd4, 32'h12345000, 1'b0};
        tbl[4] = '{32'h0040006F, 3'd5, 32'h00000004, 1'b0};
        tbl[5] = '{32'h80000000, 3'd5, 32'hFFF00000, 1'b0};
        tbl[6] = '{32'hFFFF8073, 3'd6, 32'h0000001F, 1'b0};
        tbl[7] = '{32'hFFFFFFFF, 3'd0, 32'h00000000, 1'b0};
        tbl[8] = '{32'h12345678, 3'd7, 32'h00000000, 1'b1};
        tbl[9] = '{32'h800000B7, 3'd4, 32'h80000000, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
        chk("rst_imm", imm_b, 64'd0);
        chk("rst_illegal", {63'd0, illegal_a}, 64'd0);
        chk("rst_err_cnt", {56'd0, err_a}, 64'd0);
        rst_n = 1'b1;

        // Directed format vectors, streamed back to back
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, tbl[i].instr, tbl[i].sel, 1'b1);
            chk("tbl_imm", {32'd0, imm_a}, {32'd0, tbl[i].exp});
            chk("tbl_illegal", {63'd0, illegal_a}, {63'd0, tbl[i].ill});
        end
        chk("u64_sext", imm_b, 64'hFFFFFFFF80000000);
        cycle(1'b0, 32'd0, 3'd0, 1'b1);

        // Backpressure: three offers with out_ready low, only two taken
        for (int i = 1; i <= 3; i++) cycle(1'b1, 32'(i) << 20, 3'd1, 1'b0);
        chk("bp_in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("bp_head", {32'd0, imm_a}, 64'd1);
        repeat (3) cycle(1'b0, 32'd0, 3'd0, 1'b0);
        chk("bp_hold", {32'd0, imm_a}, 64'd1);
        cycle(1'b0, 32'd0, 3'd0, 1'b1);
        chk("bp_second", {32'd0, imm_a}, 64'd2);
        cycle(1'b0, 32'd0, 3'd0, 1'b1);
        chk("bp_drained", {63'd0, out_valid_a}, 64'd0);

        // Illegal-select saturation on the 2-bit counter
        repeat (5) cycle(1'b1, $urandom, 3'd7, 1'b1);
        chk("sat_err_b", {62'd0, err_b}, 64'd3);
        cycle(1'b0, 32'd0, 3'd0, 1'b1);

        // Asynchronous reset while both entries are full
        cycle(1'b1, 32'h00500000, 3'd1, 1'b0);
        cycle(1'b1, 32'h00600000, 3'd7, 1'b0);
        chk("two_in_ready", {63'd0, in_ready_a}, 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready_b}, 64'd1);
        chk("arst_err_cnt", {56'd0, err_a}, 64'd0);
        chk("arst_imm", imm_b, 64'd0);
        model_q.delete();
        exp_err_a = 0;
        exp_err_b = 0;
        #1 rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) != 0, $urandom, 3'($urandom % 8), ($urandom % 3) != 0);
        end
        repeat (3) cycle(1'b0, 32'd0, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
